// File: rtl/sc_multiplier_sequencer_if.sv
// Control/status bundle between the multiply sequencer and its datapath/host.
// master: sequencer side. It takes Start, MultiplierLSB and Zero, and drives the
//         datapath selects, Busy and Done.
// slave:  datapath/host side, the mirror image of master.
interface sc_multiplier_sequencer_if #(
   parameter int DATAWIDTH_DECODER_SELECTION    = 3,
   parameter int DATAWIDTH_MUX_SELECTION        = 3,
   parameter int DATAWIDTH_ALU_SELECTION        = 4,
   parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2
);
   logic                                      SC_MULTSEQ_Start_InLow;
   logic                                      SC_MULTSEQ_MultiplierLSB_In;
   logic                                      SC_MULTSEQ_Zero_InLow;
   logic [DATAWIDTH_DECODER_SELECTION-1:0]    SC_MULTSEQ_DecoderSelectionWrite_Out;
   logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_MULTSEQ_MUXSelectionBUSA_Out;
   logic [DATAWIDTH_MUX_SELECTION-1:0]        SC_MULTSEQ_MUXSelectionBUSB_Out;
   logic [DATAWIDTH_ALU_SELECTION-1:0]        SC_MULTSEQ_ALUSelection_Out;
   logic                                      SC_MULTSEQ_RegSHIFTERLoad_OutLow;
   logic [DATAWIDTH_REGSHIFTER_SELECTION-1:0] SC_MULTSEQ_RegSHIFTERShiftSelection_OutLow;
   logic                                      SC_MULTSEQ_Busy_Out;
   logic                                      SC_MULTSEQ_Done_OutLow;

   modport master (
      input  SC_MULTSEQ_Start_InLow,
      input  SC_MULTSEQ_MultiplierLSB_In,
      input  SC_MULTSEQ_Zero_InLow,
      output SC_MULTSEQ_DecoderSelectionWrite_Out,
      output SC_MULTSEQ_MUXSelectionBUSA_Out,
      output SC_MULTSEQ_MUXSelectionBUSB_Out,
      output SC_MULTSEQ_ALUSelection_Out,
      output SC_MULTSEQ_RegSHIFTERLoad_OutLow,
      output SC_MULTSEQ_RegSHIFTERShiftSelection_OutLow,
      output SC_MULTSEQ_Busy_Out,
      output SC_MULTSEQ_Done_OutLow
   );

   modport slave (
      output SC_MULTSEQ_Start_InLow,
      output SC_MULTSEQ_MultiplierLSB_In,
      output SC_MULTSEQ_Zero_InLow,
      input  SC_MULTSEQ_DecoderSelectionWrite_Out,
      input  SC_MULTSEQ_MUXSelectionBUSA_Out,
      input  SC_MULTSEQ_MUXSelectionBUSB_Out,
      input  SC_MULTSEQ_ALUSelection_Out,
      input  SC_MULTSEQ_RegSHIFTERLoad_OutLow,
      input  SC_MULTSEQ_RegSHIFTERShiftSelection_OutLow,
      input  SC_MULTSEQ_Busy_Out,
      input  SC_MULTSEQ_Done_OutLow
   );
endinterface

// File: rtl/sc_multiplier_sequencer.sv
// Moore sequencer that runs an unsigned shift-and-add multiply
// (RegGEN3 = RegGEN1 * RegGEN2, mod 2^DATAWIDTH_BUS) on the register/ALU/shifter datapath.
// Ports: SC_MULTSEQ_CLOCK_50 (clock), SC_MULTSEQ_Reset_InLow (async reset, active low),
//        bus_if (master modport: start/LSB/zero in; selects, Busy, Done out).
// Option: defining SC_MULTSEQ_EARLYEXIT_EN ends the multiply as soon as RegGEN2 reads zero.
module sc_multiplier_sequencer #(
   parameter int DATAWIDTH_DECODER_SELECTION    = 3,
   parameter int DATAWIDTH_MUX_SELECTION        = 3,
   parameter int DATAWIDTH_ALU_SELECTION        = 4,
   parameter int DATAWIDTH_REGSHIFTER_SELECTION = 2,
   parameter int DATAWIDTH_BUS                  = 8
) (
   input  logic                      SC_MULTSEQ_CLOCK_50,
   input  logic                      SC_MULTSEQ_Reset_InLow,
   sc_multiplier_sequencer_if.master bus_if
);
   localparam int CNT_W = $clog2(DATAWIDTH_BUS + 1);

   localparam int DW = DATAWIDTH_DECODER_SELECTION;
   localparam int MW = DATAWIDTH_MUX_SELECTION;
   localparam int AW = DATAWIDTH_ALU_SELECTION;
   localparam int SW = DATAWIDTH_REGSHIFTER_SELECTION;

   localparam logic [DW-1:0] DEC_NONE = DW'(3'b111);
   localparam logic [DW-1:0] DEC_GEN1 = DW'(3'b001);
   localparam logic [DW-1:0] DEC_GEN2 = DW'(3'b010);
   localparam logic [DW-1:0] DEC_GEN3 = DW'(3'b011);
   localparam logic [MW-1:0] MUX_NONE = MW'(3'b111);
   localparam logic [MW-1:0] MUX_GEN1 = MW'(3'b001);
   localparam logic [MW-1:0] MUX_GEN2 = MW'(3'b010);
   localparam logic [MW-1:0] MUX_GEN3 = MW'(3'b011);
   localparam logic [MW-1:0] MUX_FIX0 = MW'(3'b100);
   localparam logic [AW-1:0] ALU_NONE = AW'(4'b1111);
   localparam logic [AW-1:0] ALU_PASS = AW'(4'b0000);
   localparam logic [AW-1:0] ALU_ADD  = AW'(4'b1000);
   localparam logic [SW-1:0] SH_HOLD  = SW'(2'b11);
   localparam logic [SW-1:0] SH_LEFT  = SW'(2'b01);
   localparam logic [SW-1:0] SH_RIGHT = SW'(2'b10);

   typedef enum logic [4:0] {
      S_IDLE, S_INIT_0, S_INIT_1, S_INIT_2, S_TEST_0,
      S_ADD_0, S_ADD_1, S_ADD_2,
      S_SHL_0, S_SHL_1, S_SHL_2, S_SHL_3,
      S_SHR_0, S_SHR_1, S_SHR_2, S_SHR_3,
      S_DONE_0
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_dec;

   logic            start_n, lsb;
   logic [DW-1:0]   dec;
   logic [MW-1:0]   busa, busb;
   logic [AW-1:0]   alu;
   logic            ld_n;
   logic [SW-1:0]   sh;
   logic            busy, done_n;

   assign start_n = bus_if.SC_MULTSEQ_Start_InLow;
   assign lsb     = bus_if.SC_MULTSEQ_MultiplierLSB_In;
   assign cnt_dec = cnt_q - CNT_W'(1);

`ifndef SC_MULTSEQ_EARLYEXIT_EN
   logic unused_zero;
   assign unused_zero = bus_if.SC_MULTSEQ_Zero_InLow;
`endif

   always_ff @(posedge SC_MULTSEQ_CLOCK_50 or negedge SC_MULTSEQ_Reset_InLow) begin
      if (!SC_MULTSEQ_Reset_InLow) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = S_IDLE;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE:   state_d = start_n ? S_IDLE : S_INIT_0;
         S_INIT_0: begin
            state_d = S_INIT_1;
            cnt_d   = CNT_W'(DATAWIDTH_BUS);
         end
         S_INIT_1: state_d = S_INIT_2;
         S_INIT_2: state_d = S_TEST_0;
         S_TEST_0: begin
            state_d = lsb ? S_ADD_0 : S_SHL_0;
`ifdef SC_MULTSEQ_EARLYEXIT_EN
            // Multiplier already exhausted: nothing left to accumulate.
            if (!bus_if.SC_MULTSEQ_Zero_InLow) state_d = S_DONE_0;
`endif
         end
         S_ADD_0:  state_d = S_ADD_1;
         S_ADD_1:  state_d = S_ADD_2;
         S_ADD_2:  state_d = S_SHL_0;
         S_SHL_0:  state_d = S_SHL_1;
         S_SHL_1:  state_d = S_SHL_2;
         S_SHL_2:  state_d = S_SHL_3;
         S_SHL_3:  state_d = S_SHR_0;
         S_SHR_0:  state_d = S_SHR_1;
         S_SHR_1:  state_d = S_SHR_2;
         S_SHR_2:  state_d = S_SHR_3;
         S_SHR_3: begin
            cnt_d   = cnt_dec;
            state_d = (cnt_dec == '0) ? S_DONE_0 : S_TEST_0;
         end
         S_DONE_0: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Microcode ROM: every field defaults to its idle value.
   always_comb begin
      dec    = DEC_NONE;
      busa   = MUX_NONE;
      busb   = MUX_NONE;
      alu    = ALU_NONE;
      ld_n   = 1'b1;
      sh     = SH_HOLD;
      busy   = 1'b1;
      done_n = 1'b1;
      case (state_q)
         S_INIT_0: begin busa = MUX_FIX0; alu = ALU_PASS; end
         S_INIT_1: begin busa = MUX_FIX0; alu = ALU_PASS; ld_n = 1'b0; end
         S_INIT_2: dec = DEC_GEN3;
         // RegGEN2 through the ALU so the zero flag reflects the multiplier.
         S_TEST_0: begin busa = MUX_GEN2; alu = ALU_PASS; end
         S_ADD_0: begin busa = MUX_GEN3; busb = MUX_GEN1; alu = ALU_ADD; end
         S_ADD_1: begin
            busa = MUX_GEN3; busb = MUX_GEN1; alu = ALU_ADD; ld_n = 1'b0;
         end
         S_ADD_2: dec = DEC_GEN3;
         S_SHL_0: begin busa = MUX_GEN1; alu = ALU_PASS; end
         S_SHL_1: begin busa = MUX_GEN1; alu = ALU_PASS; ld_n = 1'b0; end
         S_SHL_2: begin
            busa = MUX_GEN1; alu = ALU_PASS; ld_n = 1'b0; sh = SH_LEFT;
         end
         S_SHL_3: dec = DEC_GEN1;
         S_SHR_0: begin busa = MUX_GEN2; alu = ALU_PASS; end
         S_SHR_1: begin busa = MUX_GEN2; alu = ALU_PASS; ld_n = 1'b0; end
         S_SHR_2: begin
            busa = MUX_GEN2; alu = ALU_PASS; ld_n = 1'b0; sh = SH_RIGHT;
         end
         S_SHR_3: dec = DEC_GEN2;
         S_DONE_0: begin busy = 1'b0; done_n = 1'b0; end
         default: busy = 1'b0;
      endcase
   end

   assign bus_if.SC_MULTSEQ_DecoderSelectionWrite_Out       = dec;
   assign bus_if.SC_MULTSEQ_MUXSelectionBUSA_Out            = busa;
   assign bus_if.SC_MULTSEQ_MUXSelectionBUSB_Out            = busb;
   assign bus_if.SC_MULTSEQ_ALUSelection_Out                = alu;
   assign bus_if.SC_MULTSEQ_RegSHIFTERLoad_OutLow           = ld_n;
   assign bus_if.SC_MULTSEQ_RegSHIFTERShiftSelection_OutLow = sh;
   assign bus_if.SC_MULTSEQ_Busy_Out                        = busy;
   assign bus_if.SC_MULTSEQ_Done_OutLow                     = done_n;
endmodule

// File: doc/sc_multiplier_sequencer.md
Name: sc_multiplier_sequencer

Overview:
- Microcoded Moore controller that drives the register-bank / ALU / RegSHIFTER datapath through an unsigned shift-and-add multiply: RegGEN3 = RegGEN1 * RegGEN2, truncated to DATAWIDTH_BUS bits.
- Sits beside the datapath, in place of the fixed-program state machine.
- Adds a start/busy/done handshake and an iteration counter, so multiplies can be issued repeatedly without a reset.
- Operands are preloaded into RegGEN1 (multiplicand) and RegGEN2 (multiplier); RegFIX0 holds zero.

Parameters:
- DATAWIDTH_DECODER_SELECTION, 3, width of the write-decoder select.
- DATAWIDTH_MUX_SELECTION, 3, width of the BUSA/BUSB mux selects.
- DATAWIDTH_ALU_SELECTION, 4, width of the ALU opcode.
- DATAWIDTH_REGSHIFTER_SELECTION, 2, width of the shifter select.
- DATAWIDTH_BUS, 8, operand width; also the iteration count. Counter width is a localparam, $clog2(DATAWIDTH_BUS+1).

Ports:
- SC_MULTSEQ_CLOCK_50  in  1  system clock, rising edge.
- SC_MULTSEQ_Reset_InLow  in  1  asynchronous reset, active low.
- SC_MULTSEQ_Start_InLow  in  1  start request, level, active low.
- SC_MULTSEQ_MultiplierLSB_In  in  1  bit 0 of RegGEN2.
- SC_MULTSEQ_Zero_InLow  in  1  ALU zero flag, active low (0 = result zero).
- SC_MULTSEQ_DecoderSelectionWrite_Out  out  DATAWIDTH_DECODER_SELECTION  write select (111 = none).
- SC_MULTSEQ_MUXSelectionBUSA_Out  out  DATAWIDTH_MUX_SELECTION  BUSA source.
- SC_MULTSEQ_MUXSelectionBUSB_Out  out  DATAWIDTH_MUX_SELECTION  BUSB source.
- SC_MULTSEQ_ALUSelection_Out  out  DATAWIDTH_ALU_SELECTION  ALU opcode.
- SC_MULTSEQ_RegSHIFTERLoad_OutLow  out  1  shifter load, active low.
- SC_MULTSEQ_RegSHIFTERShiftSelection_OutLow  out  DATAWIDTH_REGSHIFTER_SELECTION  01 = left, 10 = right, 00/11 = hold.
- SC_MULTSEQ_Busy_Out  out  1  high in every state except IDLE and DONE_0.
- SC_MULTSEQ_Done_OutLow  out  1  low for exactly one cycle, in DONE_0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset: state <- IDLE, counter <- 0.
- IDLE outputs, also used as the default for every unlisted field: Decoder 111, BUSA 111, BUSB 111, ALU 1111, Load 1, Shift 11, Busy 0, Done 1.
- All outputs are decoded combinationally from the state register only (Moore).
- IDLE: stays in IDLE while Start_InLow = 1. Start_InLow = 0 at a clock edge -> INIT_0.
- Start is ignored in every other state.
- If Start is still low when DONE_0 returns to IDLE, a new multiply begins on the next edge.
- INIT_0/1/2 (MOV RegGEN3 <- RegFIX0):
  - INIT_0: BUSA 100, ALU 0000; counter <- DATAWIDTH_BUS on exit.
  - INIT_1: as INIT_0, plus Load 0.
  - INIT_2: Decoder 011.
  - Exit -> TEST_0.
- TEST_0: BUSA 010, ALU 0000 (RegGEN2 passes through the ALU so the flags are valid).
  - MultiplierLSB_In = 1 -> ADD_0; otherwise -> SHL_0.
- ADD_0/1/2 (RegGEN3 = RegGEN3 + RegGEN1):
  - ADD_0: BUSA 011, BUSB 001, ALU 1000.
  - ADD_1: as ADD_0, plus Load 0.
  - ADD_2: Decoder 011.
  - Exit -> SHL_0.
- SHL_0..3 (RegGEN1 <<= 1):
  - SHL_0: BUSA 001, ALU 0000.
  - SHL_1: as SHL_0, plus Load 0.
  - SHL_2: as SHL_1, plus Shift 01.
  - SHL_3: Decoder 001.
  - Exit -> SHR_0.
- SHR_0..3 (RegGEN2 >>= 1): same pattern as SHL with BUSA 010, Shift 10, Decoder 010.
  - Counter decrements on the SHR_3 exit edge.
  - If the decremented value is 0 -> DONE_0; otherwise -> TEST_0.
- DONE_0: Done_OutLow = 0, Busy = 0, all datapath fields idle. Always -> IDLE.
- Cycle cost:
  - INIT = 3 cycles.
  - Per iteration = 9 cycles, or 12 cycles when the LSB is 1.
  - DONE_0 is entered N cycles after the edge that sampled Start: N = 3 + sum over iterations.
- Arithmetic: no carry/overflow handling; the product wraps modulo 2^DATAWIDTH_BUS.
- Reset mid-operation: the sequencer returns to IDLE immediately with idle outputs. No write strobe may be emitted after reset asserts. Register contents are undefined.
- Undefined state encodings -> IDLE next cycle, with idle outputs.

Optional Feature:
- Macro: SC_MULTSEQ_EARLYEXIT_EN.
- Defined: in TEST_0, Zero_InLow = 0 (RegGEN2 == 0) -> DONE_0 directly, skipping all remaining iterations. The counter bound still applies.
- Not defined: the Zero_InLow input is unused, and exactly DATAWIDTH_BUS iterations always run.

Test Plan:
- Reset value: Reset_InLow = 0 asynchronously, mid-clock -> all outputs equal the IDLE pattern before the next edge; Busy 0, Done 1.
- Full multiply: W=8, RegGEN1 = 3, RegGEN2 = 0xFF, start -> eight ADD sequences; DONE_0 entered 99 cycles after the start edge; RegGEN3 = 0xFD (765 mod 256); Done low for exactly one cycle.
- Zero multiplier, no macro: RegGEN2 = 0 -> no Decoder 011 after INIT; DONE_0 at cycle 75; RegGEN3 = 0.
- Early exit, SC_MULTSEQ_EARLYEXIT_EN defined:
  - RegGEN2 = 0 -> DONE_0 at cycle 4.
  - RegGEN1 = 7, RegGEN2 = 5 -> DONE_0 at cycle 37; RegGEN3 = 35.
- Reset mid-ADD_1: state -> IDLE; Decoder stays 111; a fresh start then gives the correct product.
- Start held low across DONE_0: back-to-back multiplies; Start pulses while Busy = 1 are ignored (no restart, counter undisturbed).
